// File: rtl/vertex_value_writeback_pkg.sv
// Shared widths, latencies and FSM encoding for the vertex-value writeback path.
package vertex_value_writeback_pkg;

  localparam int CORE_NUM       = 32;
  localparam int V_VALUE_WIDTH  = 32;
  localparam int V_VALUE_AWIDTH = 14;
  localparam int HBM_AWIDTH     = 64;
  localparam int URAM_DELAY     = 4;
  localparam int LINE_BYTES     = 128;
  localparam int LINE_SHIFT     = $clog2(LINE_BYTES);
  localparam int LINE_WIDTH     = CORE_NUM * V_VALUE_WIDTH;
  localparam int LANE_IDX_W     = $clog2(CORE_NUM);
  // Wide enough for ((2^32-1)+31)>>5 lines.
  localparam int LINE_CT_W      = 28;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

endpackage

// File: rtl/vertex_value_writeback_wb_line_fifo.sv
// First-word-fall-through line buffer; head is read straight from storage flops.
module wb_line_fifo #(
  parameter int W     = 1024,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // Storage is not reset, so an empty buffer presents zeros instead of stale lines.
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/vertex_value_writeback.sv
// Reads one local address across all cores per line and streams the lines to HBM.
module vertex_value_writeback
  import vertex_value_writeback_pkg::*;
#(
  parameter int                    FIFO_DEPTH = 8,
  parameter logic [HBM_AWIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [31:0]                 vertex_num,
  output logic [V_VALUE_AWIDTH-1:0]   uram_rd_addr,
  output logic                        uram_rd_valid,
  input  logic [LINE_WIDTH-1:0]       uram_rd_data,
  output logic [HBM_AWIDTH-1:0]       hbm_wr_addr,
  output logic [LINE_WIDTH-1:0]       hbm_wr_data,
  output logic                        hbm_wr_valid,
  input  logic                        hbm_wr_ready,
  output logic                        busy,
  output logic                        done,
  output wb_state_e                   dbg_state_o,
  output logic [$clog2(FIFO_DEPTH):0] dbg_fifo_count_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_state_e              state_q, state_d;
  logic [LINE_CT_W-1:0]   line_total_q, rd_ct_q, wr_ct_q, ret_ct_q;
  logic [LANE_IDX_W-1:0]  rem_q;
  logic [URAM_DELAY-1:0]  dly_q;
  logic [LINE_CT_W-1:0]   start_lines;
  logic [31:0]            occupancy;
  logic [LINE_WIDTH-1:0]  push_data;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_empty;
  logic                   start_ok, rd_fire, credit_ok, push, pop, drained, ret_last;

  assign start_lines = LINE_CT_W'(({1'b0, vertex_num} + 33'd31) >> LANE_IDX_W);
  assign start_ok    = start && (state_q == ST_IDLE || state_q == ST_DONE);

  // Credit counts lines still in the URAM pipe plus lines already buffered.
  assign occupancy = 32'($countones(dly_q)) + 32'(fifo_count);
  assign credit_ok = occupancy < 32'(FIFO_DEPTH);
  assign push      = dly_q[URAM_DELAY-1];
  assign pop       = hbm_wr_valid && hbm_wr_ready;
  assign drained   = (dly_q == '0) &&
                     (fifo_empty || (fifo_count == CW'(1) && pop));
  assign ret_last  = (ret_ct_q == line_total_q - LINE_CT_W'(1));

  always_comb begin
    state_d = state_q;
    rd_fire = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = (vertex_num == 32'd0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (credit_ok) begin
          rd_fire = 1'b1;
          if (rd_ct_q == line_total_q - LINE_CT_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drained) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dly_q        <= '0;
      line_total_q <= '0;
      rem_q        <= '0;
      rd_ct_q      <= '0;
      wr_ct_q      <= '0;
      ret_ct_q     <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= {dly_q[URAM_DELAY-2:0], rd_fire};
      if (start_ok) begin
        line_total_q <= start_lines;
        rem_q        <= vertex_num[LANE_IDX_W-1:0];
        rd_ct_q      <= '0;
        wr_ct_q      <= '0;
        ret_ct_q     <= '0;
      end else begin
        if (rd_fire) rd_ct_q  <= rd_ct_q + LINE_CT_W'(1);
        if (pop)     wr_ct_q  <= wr_ct_q + LINE_CT_W'(1);
        if (push)    ret_ct_q <= ret_ct_q + LINE_CT_W'(1);
      end
    end
  end

  // Only the final line can be partial; its lanes past vertex_num are zeroed.
  always_comb begin
    push_data = '0;
    for (int i = 0; i < CORE_NUM; i++) begin
      if (!ret_last || rem_q == '0 || LANE_IDX_W'(i) < rem_q)
        push_data[i*V_VALUE_WIDTH +: V_VALUE_WIDTH] = uram_rd_data[i*V_VALUE_WIDTH +: V_VALUE_WIDTH];
    end
  end

  wb_line_fifo #(
    .W     (LINE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_data),
    .dout_o  (hbm_wr_data),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign uram_rd_valid    = rd_fire;
  assign uram_rd_addr     = rd_ct_q[V_VALUE_AWIDTH-1:0];
  assign hbm_wr_valid     = !fifo_empty;
  assign hbm_wr_addr      = BASE_ADDR + (HBM_AWIDTH'(wr_ct_q) << LINE_SHIFT);
  assign busy             = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done             = (state_q == ST_DONE);
  assign dbg_state_o      = state_q;
  assign dbg_fifo_count_o = fifo_count;

endmodule

// File: tb/tb_vertex_value_writeback.sv
// Randomized bench: URAM model with fixed read latency, line-level expected queue, timing pins.
module tb_vertex_value_writeback;
  import vertex_value_writeback_pkg::*;

  localparam int          DEPTH = 8;
  localparam logic [63:0] BASE  = 64'h0;
  localparam int          LW    = LINE_WIDTH;

  logic                      clk = 1'b0;
  logic                      rst, start;
  logic [31:0]               vertex_num;
  logic [V_VALUE_AWIDTH-1:0] uram_rd_addr;
  logic                      uram_rd_valid;
  logic [LW-1:0]             uram_rd_data;
  logic [63:0]               hbm_wr_addr;
  logic [LW-1:0]             hbm_wr_data;
  logic                      hbm_wr_valid, hbm_wr_ready;
  logic                      busy, done;
  wb_state_e                 dbg_state;
  logic [3:0]                dbg_fifo_count;

  vertex_value_writeback #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .vertex_num(vertex_num),
    .uram_rd_addr(uram_rd_addr), .uram_rd_valid(uram_rd_valid), .uram_rd_data(uram_rd_data),
    .hbm_wr_addr(hbm_wr_addr), .hbm_wr_data(hbm_wr_data), .hbm_wr_valid(hbm_wr_valid),
    .hbm_wr_ready(hbm_wr_ready), .busy(busy), .done(done),
    .dbg_state_o(dbg_state), .dbg_fifo_count_o(dbg_fifo_count)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int            checks = 0;
  int            errors = 0;
  logic [LW-1:0] exp_q[$];
  logic [63:0]   exp_addr_q[$];
  logic [31:0]   seed = 32'h0;
  int            rd_next = 0, strobe_cnt = 0, cyc_n = 0, wr_cnt = 0;
  logic [13:0]   ret_sched[int];
  bit            rand_ready = 0, pause_seen = 0;
  logic [63:0]   last_wr_addr;
  logic [LW-1:0] last_wr_data;
  logic [LW-1:0] uram_d;
  bit            prev_stall = 0;
  logic [63:0]   prev_addr;
  logic [LW-1:0] prev_data;

  function automatic void check64(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void check_line(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    int bad;
    checks++;
    if (act !== exp) begin
      errors++;
      bad = 0;
      for (int i = CORE_NUM - 1; i >= 0; i--)
        if (act[i*32 +: 32] !== exp[i*32 +: 32]) bad = i;
      $display("FAIL %s lane %0d: got %h expected %h", name, bad, act[bad*32 +: 32], exp[bad*32 +: 32]);
    end
  endfunction

  // URAM content: value of core c at local address a, for a given fill seed.
  function automatic logic [31:0] uram_val(logic [31:0] s, int core, int addr);
    return s ^ ((32'(addr) * 32'd131 + 32'(core) + 32'd1) * 32'h9E3779B1);
  endfunction

  // Behavioural model: vertex v = 32*k + i goes to lane i of line k, zero if v >= vn.
  task automatic model_enqueue(input logic [31:0] vn);
    logic [LW-1:0] line;
    int lines;
    lines      = (int'(vn) + 31) / 32;
    seed       = $urandom;
    rd_next    = 0;
    strobe_cnt = 0;
    for (int k = 0; k < lines; k++) begin
      line = '0;
      for (int i = 0; i < CORE_NUM; i++)
        if (k * 32 + i < int'(vn)) line[i*32 +: 32] = uram_val(seed, i, k);
      exp_q.push_back(line);
      exp_addr_q.push_back(BASE + 64'(k) * 64'd128);
    end
  endtask

  // ---------------- URAM model (fixed latency) + read-side checks ----------------
  always @(negedge clk) begin
    cyc_n++;
    if (ret_sched.exists(cyc_n)) begin
      for (int i = 0; i < CORE_NUM; i++) uram_d[i*32 +: 32] = uram_val(seed, i, int'(ret_sched[cyc_n]));
      ret_sched.delete(cyc_n);
    end else begin
      for (int i = 0; i < CORE_NUM; i++) uram_d[i*32 +: 32] = $urandom;
    end
    uram_rd_data = uram_d;
    if (uram_rd_valid) begin
      check64("uram_rd_addr", 64'(uram_rd_addr), 64'(rd_next));
      rd_next++;
      strobe_cnt++;
      ret_sched[cyc_n + URAM_DELAY] = uram_rd_addr;
    end
    if (dbg_state == ST_RUN && !uram_rd_valid) pause_seen = 1;
    if (dbg_fifo_count > 4'(DEPTH)) begin
      errors++;
      $display("FAIL fifo_overflow: count %0d limit %0d", dbg_fifo_count, DEPTH);
    end
  end

  // ---------------- HBM ready driver ----------------
  initial begin
    hbm_wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      hbm_wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (prev_stall) begin
      checks++;
      if (!(hbm_wr_valid && hbm_wr_addr == prev_addr && hbm_wr_data == prev_data)) begin
        errors++;
        $display("FAIL hold_stable: valid %b addr %h, held addr %h", hbm_wr_valid, hbm_wr_addr, prev_addr);
      end
    end
    if (hbm_wr_valid && hbm_wr_ready) begin
      wr_cnt++;
      last_wr_addr = hbm_wr_addr;
      last_wr_data = hbm_wr_data;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h, expected no write", hbm_wr_addr);
      end else begin
        check64("wr_addr", hbm_wr_addr, exp_addr_q.pop_front());
        check_line("wr_data", hbm_wr_data, exp_q.pop_front());
      end
    end
    prev_stall = hbm_wr_valid && !hbm_wr_ready;
    prev_addr  = hbm_wr_addr;
    prev_data  = hbm_wr_data;
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_vals(input string tag);
    check64({tag, "_rd_valid"}, uram_rd_valid, 0);
    check64({tag, "_rd_addr"},  64'(uram_rd_addr), 0);
    check64({tag, "_wr_valid"}, hbm_wr_valid, 0);
    check64({tag, "_wr_addr"},  hbm_wr_addr, BASE);
    check64({tag, "_wr_data_nz"}, 64'(hbm_wr_data != '0), 0);
    check64({tag, "_busy"},     busy, 0);
    check64({tag, "_done"},     done, 0);
    check64({tag, "_state"},    64'(dbg_state), 64'(ST_IDLE));
  endtask

  // exp_done < 0 skips the latency pins; restart_at > 0 pulses an extra start mid-run.
  task automatic run_job(input logic [31:0] vn, input int exp_done, input int restart_at);
    int cyc, first_wr, lines, w0;
    lines = (int'(vn) + 31) / 32;
    model_enqueue(vn);
    w0 = wr_cnt;
    @(negedge clk);
    start = 1'b1;
    vertex_num = vn;
    @(negedge clk);
    start = 1'b0;
    vertex_num = $urandom;
    cyc = 1;
    first_wr = -1;
    if (vn != 0) begin
      check64("busy_at_1", busy, 1);
      check64("rd_valid_at_1", uram_rd_valid, 1);
    end
    while (!done && cyc < 20000) begin
      if (hbm_wr_valid && first_wr < 0) first_wr = cyc;
      @(negedge clk);
      cyc++;
      start = (cyc == restart_at);
    end
    start = 1'b0;
    check64("done_seen", done, 1);
    check64("busy_at_done", busy, 0);
    if (exp_done >= 0) check64("done_cycle", 64'(cyc), 64'(exp_done));
    if (exp_done >= 0 && vn != 0) check64("first_wr_cycle", 64'(first_wr), 64'(URAM_DELAY + 2));
    check64("write_count", 64'(wr_cnt - w0), 64'(lines));
    check64("strobe_count", 64'(strobe_cnt), 64'(lines));
    check64("exp_left", 64'(exp_q.size()), 0);
    @(negedge clk);
    check64("done_holds", done, 1);
  endtask

  task automatic reset_test();
    rd_next = 0;
    strobe_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    vertex_num = 32'd256;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    // rst and start together: rst must win.
    rst = 1'b1;
    start = 1'b1;
    vertex_num = 32'd64;
    @(negedge clk);
    start = 1'b0;
    check_reset_vals("mid_rst");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check64("no_wr_after_rst", hbm_wr_valid, 0);
    end
    check64("busy_after_rst", busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int vn;
    rst = 1'b1;
    start = 1'b0;
    vertex_num = '0;
    uram_rd_data = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    run_job(32'd64, URAM_DELAY + 4, -1);
    check64("vn64_last_addr", last_wr_addr, 64'h80);

    run_job(32'd33, URAM_DELAY + 4, -1);
    check64("vn33_last_addr", last_wr_addr, 64'h80);
    check64("vn33_upper_zero", 64'(last_wr_data[LW-1:32] != '0), 0);
    check64("vn33_lane0", 64'(last_wr_data[31:0]), 64'(uram_val(seed, 0, 1)));

    run_job(32'd0, 1, -1);
    run_job(32'd0, 1, -1);
    run_job(32'd64, URAM_DELAY + 4, -1);

    for (int j = 0; j < 3; j++) begin
      vn = $urandom_range(1, 300);
      run_job(32'(vn), URAM_DELAY + 2 + (vn + 31) / 32, -1);
    end

    rand_ready = 1;
    pause_seen = 0;
    run_job(32'd1024, -1, -1);
    check64("rd_pause_seen", pause_seen, 1);
    rand_ready = 0;
    repeat (2) @(negedge clk);

    run_job(32'd128, URAM_DELAY + 6, 3);

    reset_test();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vertex_value_writeback.md
# vertex_value_writeback

- Drains the per-core vertex-value URAMs back to HBM once an iteration completes.
- Each 1024-bit HBM write carries one 32-bit value from each of the 32 cores at the same local URAM address.
- Writes go out as 128 B-aligned cachelines from BASE_ADDR upward. This is the write-direction counterpart of the offset loader, which streams HBM cachelines into the URAMs.
- Sits between the core array's value URAM read port and the HBM write channel.

## Interface
- CORE_NUM, 32: cores; one 32-bit lane each per cacheline.
- V_VALUE_WIDTH, 32: value width; CORE_NUM*V_VALUE_WIDTH must equal 1024.
- V_VALUE_AWIDTH, 14: per-core URAM address width.
- HBM_AWIDTH, 64: HBM byte address width.
- URAM_DELAY, 4: fixed URAM read latency, in cycles.
- FIFO_DEPTH, 8: line buffer depth; must be ≥ URAM_DELAY+2 and a power of two.
- BASE_ADDR, 0: HBM byte address of line 0; 128 B aligned.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  pulse; begins writeback; ignored while busy.
- vertex_num  in  32  vertex count; sampled on an accepted start.
- uram_rd_addr  out  V_VALUE_AWIDTH  local address, broadcast to all cores.
- uram_rd_valid  out  1  read strobe.
- uram_rd_data  in  CORE_NUM*V_VALUE_WIDTH  lane i = core i; valid exactly URAM_DELAY cycles after the strobe.
- hbm_wr_addr  out  HBM_AWIDTH  line byte address.
- hbm_wr_data  out  1024  line data.
- hbm_wr_valid  out  1  write request.
- hbm_wr_ready  in  1  HBM accepts.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.

## Operation
- Vertex v lives in core v mod 32 at local address v>>5. Line k holds local address k across all cores.
- line_total = (vertex_num+31)>>5, computed at start.
- FSM: IDLE, RUN, DRAIN, DONE.
  - IDLE --start--> RUN; if vertex_num==0, go directly to DONE instead.
  - RUN --last read issued--> DRAIN.
  - DRAIN --in-flight==0, FIFO empty, no pending hbm_wr_valid--> DONE.
  - DONE --start--> RUN or DONE, by the same rule as from IDLE.
- Read issue: in RUN, uram_rd_valid=1 with uram_rd_addr=rd_ct when in_flight+fifo_count < FIFO_DEPTH; rd_ct then increments.
  - in_flight is the number of strobes in an internal URAM_DELAY-deep valid shift register.
  - The credit check ignores a same-cycle FIFO pop.
- Return: when the delay register's tail is set, the line is pushed into the FIFO. Lanes whose vertex index ≥ vertex_num (last line only) are forced to 0.
- Write: the FIFO head drives hbm_wr_data. hbm_wr_addr = BASE_ADDR + (wr_ct<<7). wr_ct increments on valid&&ready.
- Credit flow control guarantees the FIFO never overflows. An overflow is a design error; the bench asserts against it.

## Timing
- Reset values: uram_rd_valid=0, uram_rd_addr=0, hbm_wr_valid=0, hbm_wr_addr=BASE_ADDR, hbm_wr_data=0, busy=0, done=0. State=IDLE, counters 0, FIFO empty, delay register cleared.
- Start accepted at cycle 0:
  - busy=1 and the first read strobe at cycle 1.
  - Data captured at cycle 1+URAM_DELAY.
  - hbm_wr_valid first high at cycle 2+URAM_DELAY (registered FIFO output).
- Throughput is 1 line/cycle while hbm_wr_ready stays high.
- Handshake: hbm_wr_valid/addr/data are held stable while valid && !ready. Valid never drops without acceptance.
- done rises the cycle after the final accepted write; busy falls in the same cycle. done stays high until the next accepted start or rst.
- rst mid-operation: everything returns to reset values on the next edge.
  - The cleared delay register means in-flight URAM returns are never captured.
  - No further HBM request is issued.
- start while busy is ignored.
- start in the same cycle as rst: rst wins.

## Structure
- Shared package/header: V_VALUE_WIDTH, V_VALUE_AWIDTH, CORE_NUM, HBM_AWIDTH, URAM_DELAY, the cacheline byte size 128, and the FSM state encoding.
- One sub-module, wb_line_fifo:
  - Synchronous, first-word-fall-through, registered output.
  - Signals: push, pop, data in/out, count, empty.

## Test plan
- vertex_num=64, ready=1: lines to 0x0 and 0x80. Each lane i of line k equals the model URAM at core i / address k. done at cycle URAM_DELAY+4 after start.
- vertex_num=33: 2 lines. In line 1, lane 0 carries core0[1] and lanes 1-31 are 0.
- vertex_num=0: no URAM read, no HBM write, done=1 at cycle 1. A second start while done=1 restarts cleanly.
- vertex_num=1024 with hbm_wr_ready randomly low (50%):
  - Exactly 32 writes, in order, with addr/data stable while stalled.
  - FIFO count never exceeds FIFO_DEPTH.
  - uram_rd_valid pauses when credit runs out.
- rst asserted 3 cycles after start with vertex_num=256: all outputs return to reset values. No hbm_wr_valid appears in the following 10 cycles.
- start pulsed again while busy (vertex_num=128 run): ignored; exactly 4 writes occur.
